// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a blocking command/response
// handshake into exactly one AXI4-Lite read or write at a time.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH_p    = 4,
  parameter int ERR_CNT_WIDTH_p = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_write,
  input  logic [ADDR_WIDTH_p-1:0]    i_cmd_addr,
  input  logic [31:0]                i_cmd_wdata,
  input  logic [3:0]                 i_cmd_wstrb,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic                       o_rsp_write,
  output logic [31:0]                o_rsp_rdata,
  output logic [1:0]                 o_rsp_resp,
  output logic                       o_busy,
  output logic [ERR_CNT_WIDTH_p-1:0] o_err_cnt,
  output logic [ADDR_WIDTH_p-1:0]    o_axi_awaddr,
  output logic                       o_axi_awvalid,
  input  logic                       i_axi_awready,
  output logic [31:0]                o_axi_wdata,
  output logic [3:0]                 o_axi_wstrb,
  output logic                       o_axi_wvalid,
  input  logic                       i_axi_wready,
  input  logic [1:0]                 i_axi_bresp,
  input  logic                       i_axi_bvalid,
  output logic                       o_axi_bready,
  output logic [ADDR_WIDTH_p-1:0]    o_axi_araddr,
  output logic                       o_axi_arvalid,
  input  logic                       i_axi_arready,
  input  logic [31:0]                i_axi_rdata,
  input  logic [1:0]                 i_axi_rresp,
  input  logic                       i_axi_rvalid,
  output logic                       o_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R, RSP} state_e;

  localparam logic [ADDR_WIDTH_p-1:0] LOW_BITS_lp = ADDR_WIDTH_p'(3);

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH_p-1:0]    addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [3:0]                 wstrb_q, wstrb_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic                       rsp_write_q, rsp_write_d;
  logic [31:0]                rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                 rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_WIDTH_p-1:0] err_cnt_q, err_cnt_d;
  logic                       cap_en;
  logic [1:0]                 cap_resp;

  function automatic logic [ERR_CNT_WIDTH_p-1:0] sat_inc(input logic [ERR_CNT_WIDTH_p-1:0] v);
    if (&v) return v;
    return v + ERR_CNT_WIDTH_p'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_cnt_d   = err_cnt_q;
    cap_en      = 1'b0;
    cap_resp    = 2'b00;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          addr_d    = i_cmd_addr & ~LOW_BITS_lp;
          wdata_d   = i_cmd_wdata;
          wstrb_d   = i_cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = i_cmd_write ? WR : RD;
        end
      end
      WR: begin
        // AW and W complete independently; wait until both have handshaken
        aw_done_d = aw_done_q | i_axi_awready;
        w_done_d  = w_done_q | i_axi_wready;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (i_axi_bvalid) begin
          cap_en      = 1'b1;
          cap_resp    = i_axi_bresp;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD: begin
        if (i_axi_arready) state_d = RD_R;
      end
      RD_R: begin
        if (i_axi_rvalid) begin
          cap_en      = 1'b1;
          cap_resp    = i_axi_rresp;
          rsp_write_d = 1'b0;
          rsp_rdata_d = i_axi_rdata;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cap_en) begin
      rsp_resp_d = cap_resp;
      if (cap_resp != 2'b00) err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_cmd_ready   = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_axi_awvalid = (state_q == WR) && !aw_done_q;
  assign o_axi_wvalid  = (state_q == WR) && !w_done_q;
  assign o_axi_bready  = (state_q == WR_B);
  assign o_axi_arvalid = (state_q == RD);
  assign o_axi_rready  = (state_q == RD_R);
  assign o_rsp_valid   = (state_q == RSP);
  assign o_axi_awaddr  = addr_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_rsp_write   = rsp_write_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a scratchpad-like AXI-Lite slave model with
// programmable ready delays and error responses, plus a response scoreboard.
module tb_axi_lite_cmd_master;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [7:0] err_cnt;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  // second instance with a 2-bit error counter; its AXI outputs mirror the first
  logic d2_cmd_ready, d2_rsp_valid, d2_rsp_write, d2_busy;
  logic [31:0] d2_rsp_rdata, d2_wdata;
  logic [1:0] d2_rsp_resp, d2_err_cnt;
  logic [AW-1:0] d2_awaddr, d2_araddr;
  logic d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready;
  logic [3:0] d2_wstrb;

  axi_lite_cmd_master #(.ADDR_WIDTH_p(AW), .ERR_CNT_WIDTH_p(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_busy(busy), .o_err_cnt(err_cnt),
    .o_axi_awaddr(awaddr), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .o_axi_araddr(araddr), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid), .o_axi_rready(rready)
  );

  axi_lite_cmd_master #(.ADDR_WIDTH_p(AW), .ERR_CNT_WIDTH_p(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(d2_cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(d2_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(d2_rsp_write),
    .o_rsp_rdata(d2_rsp_rdata), .o_rsp_resp(d2_rsp_resp), .o_busy(d2_busy), .o_err_cnt(d2_err_cnt),
    .o_axi_awaddr(d2_awaddr), .o_axi_awvalid(d2_awvalid), .i_axi_awready(awready),
    .o_axi_wdata(d2_wdata), .o_axi_wstrb(d2_wstrb), .o_axi_wvalid(d2_wvalid), .i_axi_wready(wready),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(d2_bready),
    .o_axi_araddr(d2_araddr), .o_axi_arvalid(d2_arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid), .o_axi_rready(d2_rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [4];
  int aw_dly = 0, w_dly = 0, aw_cnt, w_cnt;
  logic err_b = 1'b0, err_r = 1'b0, stray_b = 1'b0, stray_r = 1'b0;
  logic aw_got, w_got, bvalid_q, rvalid_q;
  logic [AW-1:0] aw_lat, last_awaddr, last_araddr;
  logic [31:0] wd_lat, rdata_q;
  logic [3:0] ws_lat;
  logic [1:0] bresp_q, rresp_q;
  logic aw_hs, w_hs, wr_fire;
  logic [AW-1:0] wa;
  logic [31:0] wd;
  logic [3:0] ws;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid;
  assign bvalid  = bvalid_q | stray_b;
  assign bresp   = stray_b ? 2'b10 : bresp_q;
  assign rvalid  = rvalid_q | stray_r;
  assign rresp   = stray_r ? 2'b11 : rresp_q;
  assign rdata   = rdata_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
  assign wa      = aw_hs ? awaddr : aw_lat;
  assign wd      = w_hs ? wdata : wd_lat;
  assign ws      = w_hs ? wstrb : ws_lat;

  initial for (int k = 0; k < 4; k++) mem[k] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0; bresp_q <= '0; rresp_q <= '0; rdata_q <= '0;
      aw_lat <= '0; wd_lat <= '0; ws_lat <= '0; last_awaddr <= '0; last_araddr <= '0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      if (wvalid && !wready) w_cnt <= w_cnt + 1;
      if (aw_hs) begin aw_cnt <= 0; aw_got <= 1'b1; aw_lat <= awaddr; last_awaddr <= awaddr; end
      if (w_hs) begin w_cnt <= 0; w_got <= 1'b1; wd_lat <= wdata; ws_lat <= wstrb; end
      if (wr_fire) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mem[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b1;
        bresp_q <= err_b ? 2'b10 : 2'b00;
      end
      if (bvalid_q && bready) bvalid_q <= 1'b0;
      if (arvalid && arready) begin
        rvalid_q <= 1'b1; rdata_q <= mem[araddr[3:2]];
        rresp_q <= err_r ? 2'b11 : 2'b00; last_araddr <= araddr;
      end
      if (rvalid_q && rready) rvalid_q <= 1'b0;
    end
  end

  // ---------------- scoreboard and channel monitor ----------------
  typedef struct packed { logic wr; logic [31:0] rdata; logic [1:0] resp; } rsp_t;
  rsp_t exp_q[$];
  int aw_cyc = 0, w_cyc = 0, viol = 0, rsp_seen = 0;

  initial begin
    rsp_t e;
    logic prev_aw, prev_w;
    logic [AW-1:0] prev_awaddr;
    logic [31:0] prev_wdata;
    prev_aw = 1'b0; prev_w = 1'b0; prev_awaddr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=rsp_valid required=no response");
        end else begin
          e = exp_q.pop_front();
          check("rsp_write", rsp_write, e.wr);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
        end
      end
      if (cmd_valid && cmd_ready) begin aw_cyc = 0; w_cyc = 0; end
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (bready && (awvalid || wvalid)) viol++;
      if (awvalid && prev_aw && awaddr != prev_awaddr) viol++;
      if (wvalid && prev_w && wdata != prev_wdata) viol++;
      prev_aw = awvalid; prev_w = wvalid; prev_awaddr = awaddr; prev_wdata = wdata;
    end
  end

  // called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input rsp_t e);
    bit ok = 0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; exp_q.push_back(e); end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL cmd_accept actual=not accepted required=accepted within 100 cycles");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=pending=%0d required=pending=0", name, exp_q.size());
    end
  endtask

  typedef struct {
    logic wr; logic [AW-1:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    int aw_dly; int w_dly; logic err; logic [31:0] exp_rdata; logic [1:0] exp_resp;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s,
                              int awd, int wdl, logic er, logic [31:0] xr, logic [1:0] xp);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.wstrb = s; v.aw_dly = awd; v.w_dly = wdl;
    v.err = er; v.exp_rdata = xr; v.exp_resp = xp;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    rsp_t e;
    logic [34:0] snap;
    bit ok;
    int n, seen0;

    vecs[0]  = mk(1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 2'b00);
    vecs[1]  = mk(0, 4'h4, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00);
    vecs[2]  = mk(1, 4'h8, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 32'h0, 2'b00);
    vecs[3]  = mk(1, 4'h8, 32'h12345678, 4'h3, 0, 0, 0, 32'h0, 2'b00);
    vecs[4]  = mk(0, 4'h8, 32'h0,        4'h0, 0, 0, 0, 32'hAAAA5678, 2'b00);
    vecs[5]  = mk(1, 4'hC, 32'h11111111, 4'hF, 3, 0, 0, 32'h0, 2'b00);
    vecs[6]  = mk(1, 4'hC, 32'h22222222, 4'hC, 0, 3, 0, 32'h0, 2'b00);
    vecs[7]  = mk(0, 4'hC, 32'h0,        4'h0, 0, 0, 0, 32'h22221111, 2'b00);
    vecs[8]  = mk(1, 4'h0, 32'h00000055, 4'hF, 0, 0, 1, 32'h0, 2'b10);
    vecs[9]  = mk(1, 4'h1, 32'h00000066, 4'hF, 1, 1, 1, 32'h0, 2'b10);
    vecs[10] = mk(0, 4'h0, 32'h0,        4'h0, 0, 0, 1, 32'h00000066, 2'b11);
    vecs[11] = mk(0, 4'h6, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00);
    vecs[12] = mk(1, 4'h8, 32'h99999999, 4'hC, 0, 0, 1, 32'h0, 2'b10);
    vecs[13] = mk(0, 4'h8, 32'h0,        4'h0, 0, 0, 1, 32'h99995678, 2'b11);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("rst_axi_fields", {awaddr, araddr, wdata, wstrb}, '0);
    check("rst_rsp_fields", {rsp_write, rsp_rdata, rsp_resp}, '0);
    check("rst_err_cnt", err_cnt, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait write latency: rsp_valid three cycles after accept
    e = '{wr: 1'b1, rdata: 32'h0, resp: 2'b00};
    issue(1'b1, 4'h0, 32'h0BADF00D, 4'hF, e);
    n = 0; ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); n++;
      ok = rsp_valid;
    end
    check("write_latency", n, 3);
    wait_done("latency");

    for (int i = 0; i < 14; i++) begin
      aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly;
      err_b = vecs[i].err && vecs[i].wr;
      err_r = vecs[i].err && !vecs[i].wr;
      e = '{wr: vecs[i].wr, rdata: vecs[i].exp_rdata, resp: vecs[i].exp_resp};
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, e);
      wait_done($sformatf("vec%0d", i));
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_awvalid_cycles", i), aw_cyc, vecs[i].aw_dly + 1);
        check($sformatf("vec%0d_wvalid_cycles", i), w_cyc, vecs[i].w_dly + 1);
        check($sformatf("vec%0d_awaddr", i), last_awaddr, vecs[i].addr & 4'hC);
      end else begin
        check($sformatf("vec%0d_araddr", i), last_araddr, vecs[i].addr & 4'hC);
      end
      if (i == 10) begin
        check("err_cnt_after_3", err_cnt, 8'd3);
        check("err_cnt2_after_3", d2_err_cnt, 2'd3);
      end
    end
    aw_dly = 0; w_dly = 0; err_b = 1'b0; err_r = 1'b0;
    check("err_cnt_after_5", err_cnt, 8'd5);
    check("err_cnt2_saturated", d2_err_cnt, 2'd3);

    // response back-pressure; command inputs wiggle while busy
    rsp_ready = 1'b0;
    e = '{wr: 1'b0, rdata: 32'hDEADBEEF, resp: 2'b00};
    issue(1'b0, 4'h4, 32'h0, 4'h0, e);
    cmd_addr = 4'h8; cmd_write = 1'b1; cmd_wdata = 32'hFFFFFFFF; cmd_wstrb = 4'hF;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    check("hold_rsp_seen", ok, 1'b1);
    snap = {rsp_write, rsp_rdata, rsp_resp};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold_stable%0d", k), {rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp},
            {1'b1, 1'b0, snap});
      if (k < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("cmd_ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    wait_done("hold");

    // asynchronous reset in the middle of a write
    aw_dly = 10;
    e = '{wr: 1'b1, rdata: 32'h0, resp: 2'b00};
    issue(1'b1, 4'h4, 32'h13572468, 4'hF, e);
    @(negedge clk);
    check("midwr_awvalid", awvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_axi_handshakes", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("arst_cmd_ready", cmd_ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_err_cnt", {err_cnt, d2_err_cnt}, 10'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    aw_dly = 0;
    seen0 = rsp_seen;
    repeat (10) @(posedge clk);
    #1;
    check("no_rsp_after_reset", rsp_seen - seen0, 0);
    check("idle_after_reset", busy, 1'b0);

    // stray B/R valids while idle must be ignored
    stray_b = 1'b1; stray_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stray_b = 1'b0; stray_r = 1'b0;
    @(posedge clk); #1;
    check("stray_busy", busy, 1'b0);
    check("stray_err_cnt", err_cnt, 8'd0);
    check("stray_no_rsp", rsp_seen - seen0, 0);

    // normal operation after reset; memory contents survive in the slave
    e = '{wr: 1'b0, rdata: 32'hDEADBEEF, resp: 2'b00};
    issue(1'b0, 4'h4, 32'h0, 4'h0, e);
    wait_done("post_reset_read");
    check("channel_protocol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
